memory_arbiter: RTL
===================

# memory_arbiter

Sequential arbiter sharing the single RAM port between the datapath's instruction fetch (iREN) and data access (dREN/dWEN) requests. It sits between the datapath/caches and the RAM model. It holds a registered grant until the RAM reports completion, and gives data accesses priority so LW/SW make forward progress. A watchdog flags a RAM that never completes.

## Interface
- TIMEOUT, 64: max cycles a grant may wait for ramstate == ACCESS before aborting (≥2).
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- iwait  out  1  instruction request not yet served.
- iload  out  32  instruction data; valid when iREN && !iwait.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; dREN and dWEN are never both high.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  data request not yet served.
- dload  out  32  read data; valid when dREN && !dwait.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- timeout  out  1  sticky watchdog flag; cleared only by RST.

## Operation
- FSM states (arb_state_t): IDLE, DGRANT, IGRANT.
- IDLE: no RAM enables; ramaddr/ramstore = 0. Next state:
  - if (dREN||dWEN): DGRANT;
  - else if iREN: IGRANT;
  - else IDLE.
- DGRANT: ramaddr = daddr, ramstore = dstore, ramREN = dREN, ramWEN = dWEN.
- IGRANT: ramaddr = iaddr, ramREN = 1, ramWEN = 0.
- Completion: in a grant state with ramstate == ACCESS, the granted wait is 0 in that same cycle and ramload is passed combinationally to dload or iload. Next state is IDLE.
- ERROR and BUSY/FREE: the grant is held and the access retried; the wait signal stays 1.
- Abort: if the granted requester drops its request (e.g. dREN && dWEN both 0 in DGRANT), the enables deassert combinationally and the next state is IDLE.
- Watchdog: a counter (width $clog2(TIMEOUT+1)) clears on entering a grant state and increments each grant cycle without ACCESS. When it reaches TIMEOUT-1, the next state is IDLE and timeout sets.
- Wait signals: iwait = iREN && !(IGRANT && ACCESS); dwait = (dREN||dWEN) && !(DGRANT && ACCESS).
- iload/dload are 0 whenever not completing.

## Timing
- Reset: state IDLE, counter 0, timeout 0, last-served bit 0.
- Reset outputs: ramREN 0, ramWEN 0, ramaddr 0, ramstore 0, iwait = iREN, dwait = dREN||dWEN, iload 0, dload 0.
- Latency: request seen in IDLE at edge N, so grant begins at cycle N+1. With a k-cycle RAM, ACCESS arrives at cycle N+k and wait drops that cycle.
- There is one mandatory IDLE turnaround cycle between consecutive grants, so back-to-back accesses cost k+1 cycles each.
- RST mid-grant: the FSM returns to IDLE immediately and the enables drop asynchronously.
- Simultaneous i/d requests in IDLE: resolved by the priority rule only. An in-progress grant is never pre-empted.

## Configuration
- MEMORY_ARBITER_FAIR_EN defined:
  - A last-served flop (0 = instruction, 1 = data) updates on each completion.
  - When both requests are pending in IDLE, the requester not last served wins.
- MEMORY_ARBITER_FAIR_EN undefined:
  - Data has strict priority.
  - The flop is not synthesized.

## Structure
- Put arb_state_t in cpu_types_pkg alongside ramstate_t and word_t.
- Put the TIMEOUT default as a localparam in cpu_types_pkg.
- One sub-module is natural: arb_watchdog, the TIMEOUT counter with clear, enable and expired outputs.

## Test plan
- Single iREN, iaddr=0x40, RAM latency 2, ramload=0x3C010001:
  - IGRANT at the next edge, ACCESS 2 cycles later.
  - iwait drops that cycle and iload=0x3C010001.
- iREN and dREN both high, FAIR_EN undefined:
  - DGRANT first, IDLE, then IGRANT.
  - Repeat with FAIR_EN defined and last-served=data: IGRANT first.
- SW daddr=0x100, dstore=0xDEADBEEF:
  - ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF until ACCESS.
  - ramREN stays 0 throughout.
- RAM held BUSY, TIMEOUT=4:
  - The FSM returns to IDLE after 4 grant cycles.
  - timeout=1 and stays 1 until RST.
- ERROR for 2 cycles then ACCESS:
  - The grant is held and the request re-driven.
  - dwait=1 until ACCESS.
- RST pulsed mid-DGRANT:
  - ramREN/ramWEN drop to 0 without waiting for a clock edge.
  - The state is IDLE after RST deasserts.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, arbiter FSM states and the word type.
// Also holds the default watchdog limit used by memory_arbiter.
package cpu_types_pkg;

    localparam int ARB_TIMEOUT = 64;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arb_state_t;

    function automatic logic is_grant(arb_state_t s);
        return (s == DGRANT) || (s == IGRANT);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Grant watchdog: counts grant cycles that did not complete and flags expiry
// on the cycle the count reaches TIMEOUT-1.
module arb_watchdog
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single RAM port between instruction fetch and data access.
// Define MEMORY_ARBITER_FAIR_EN to alternate between requesters on contention.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      timeout
);

    arb_state_t state, next_state;

    logic d_req;
    logic ram_done;
    logic granted_req;
    logic i_done;
    logic d_done;
    logic pick_data;
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;
    logic set_timeout;

    assign d_req       = dREN || dWEN;
    assign ram_done    = (ramstate == ACCESS);
    assign granted_req = ((state == DGRANT) && d_req) || ((state == IGRANT) && iREN);
    assign i_done      = (state == IGRANT) && ram_done && iREN;
    assign d_done      = (state == DGRANT) && ram_done && d_req;

    assign iwait = iREN  && !((state == IGRANT) && ram_done);
    assign dwait = d_req && !((state == DGRANT) && ram_done);
    assign iload = i_done ? ramload : '0;
    assign dload = d_done ? ramload : '0;

`ifdef MEMORY_ARBITER_FAIR_EN
    // 1 = data was served most recently, so instruction wins the next tie
    logic last_data;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_data <= 1'b0;
        end else if (d_done) begin
            last_data <= 1'b1;
        end else if (i_done) begin
            last_data <= 1'b0;
        end
    end

    assign pick_data = d_req && !(iREN && last_data);
`else
    assign pick_data = d_req;
`endif

    assign wd_clear  = !is_grant(state);
    assign wd_enable = granted_req && !ram_done;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (CLK),
        .rst     (RST),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timeout <= 1'b0;
        end else if (set_timeout) begin
            timeout <= 1'b1;
        end
    end

    // A grant ends on completion, on the requester dropping out, or on expiry
    always_comb begin
        next_state  = state;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (pick_data) begin
                    next_state = DGRANT;
                end else if (iREN) begin
                    next_state = IGRANT;
                end else begin
                    next_state = IDLE;
                end
            end
            DGRANT, IGRANT: begin
                if (!granted_req || ram_done) begin
                    next_state = IDLE;
                end else if (wd_expired) begin
                    next_state  = IDLE;
                    set_timeout = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramREN   = dREN;
                ramWEN   = dWEN;
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

endmodule
